// File: rtl/sys_unit_if.sv
// sys_unit_if: syscall request, result write-back and output-FIFO drain
// signals of the system-call unit.
//   slave  : the unit itself (takes the syscall request and out_ready,
//            returns stall/halted/result/display and the FIFO head)
//   master : the core side and the output consumer
interface sys_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 2
);
  logic             sys_valid;
  logic [WIDTH-1:0] sys_code;
  logic [WIDTH-1:0] sys_arg;
  logic             stall;
  logic             halted;
  logic [WIDTH-1:0] result;
  logic             result_we;
  logic [WIDTH-1:0] display;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_chan;

  modport slave (
    input  sys_valid, sys_code, sys_arg, out_ready,
    output stall, halted, result, result_we, display,
           out_valid, out_data, out_chan
  );

  modport master (
    output sys_valid, sys_code, sys_arg, out_ready,
    input  stall, halted, result, result_we, display,
           out_valid, out_data, out_chan
  );
endinterface

// File: rtl/sys_unit.sv
// sys_unit: system-call unit for the MIPS core.
// Decodes the service code ($v0) and argument ($a0) of a syscall:
//   HALT_CODE  - stop the core (sticky until reset)
//   PRINT_CODE - push {channel, arg} into the output FIFO, update display
//   CHAN_CODE  - select the output channel (arg % CHANNELS)
//   CYCLE_CODE - return the free-running cycle counter on result
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sys_unit_if.slave (syscall request, stall/halted,
//                result write-back, display, FIFO valid/ready drain)
module sys_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HALT_CODE  = 10,
  parameter int unsigned PRINT_CODE = 1,
  parameter int unsigned CHAN_CODE  = 2,
  parameter int unsigned CYCLE_CODE = 30
) (
  input logic     clk,
  input logic     rst_n,
  sys_unit_if.slave bus
);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(DEPTH + 1);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t            state, state_nxt;
  logic              act;
  logic              is_halt, is_print, is_chan, is_cycle;
  logic [WIDTH-1:0]  counter;
  logic [WIDTH-1:0]  display_q;
  logic [CW-1:0]     chan;

  logic [CW+WIDTH-1:0] mem [DEPTH];
  logic [CW+WIDTH-1:0] head;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [NW-1:0]       count;
  logic                full, push, pop, fifo_valid;

  assign is_halt  = bus.sys_code == WIDTH'(HALT_CODE);
  assign is_print = bus.sys_code == WIDTH'(PRINT_CODE);
  assign is_chan  = bus.sys_code == WIDTH'(CHAN_CODE);
  assign is_cycle = bus.sys_code == WIDTH'(CYCLE_CODE);

  // Once halted, syscall requests are ignored entirely.
  assign act = bus.sys_valid & (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (act && is_halt) state_nxt = ST_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter   <= '0;
      display_q <= '0;
      chan      <= '0;
    end else begin
      if (state == ST_RUN) counter <= counter + WIDTH'(1);
      if (push)            display_q <= bus.sys_arg;
      if (act && is_chan)  chan <= CW'(bus.sys_arg % WIDTH'(CHANNELS));
    end
  end

  // Output FIFO. A pop never frees space for a push in the same cycle, so
  // stall depends only on the registered count, not on out_ready.
  assign full       = count == NW'(DEPTH);
  assign fifo_valid = count != '0;
  assign push       = act & is_print & ~full;
  assign pop        = fifo_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {chan, bus.sys_arg};
  end

  assign head = mem[rd_ptr];

  assign bus.stall     = act & is_print & full;
  assign bus.halted    = state == ST_HALT;
  assign bus.result_we = act & is_cycle;
  assign bus.result    = (act & is_cycle) ? counter : '0;
  assign bus.display   = display_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = head[WIDTH-1:0];
  assign bus.out_chan  = head[CW+WIDTH-1:WIDTH];
endmodule

// File: tb/tb_sys_unit.sv
// tb_sys_unit: directed bench for sys_unit. Main instance uses default
// parameters; a second 4-bit instance exercises counter wrap-around.
module tb_sys_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sys_unit_if #(.WIDTH(32), .CW(2)) bus0 ();
  sys_unit_if #(.WIDTH(4),  .CW(2)) bus1 ();

  sys_unit u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  sys_unit #(
    .WIDTH      (4),
    .CHANNELS   (4),
    .DEPTH      (2),
    .CYCLE_CODE (14)
  ) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] code, input logic [31:0] arg);
    bus0.sys_valid = 1'b1;
    bus0.sys_code  = code;
    bus0.sys_arg   = arg;
  endtask

  task automatic idle();
    bus0.sys_valid = 1'b0;
    bus0.sys_code  = '0;
    bus0.sys_arg   = '0;
  endtask

  logic [31:0] drain_exp [8];

  initial begin
    rst_n = 1'b0;
    idle();
    bus0.out_ready = 1'b0;
    bus1.sys_valid = 1'b0;
    bus1.sys_code  = '0;
    bus1.sys_arg   = '0;
    bus1.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_halted",    bus0.halted,    1'b0);
    chk("rst_out_valid", bus0.out_valid, 1'b0);
    chk("rst_display",   bus0.display,   32'h0);
    chk("rst_stall",     bus0.stall,     1'b0);
    rst_n = 1'b1;
    bus1.sys_valid = 1'b1;
    bus1.sys_code  = 4'd14;

    // Cycle read in the 5th cycle after release
    repeat (4) @(negedge clk);
    issue(30, 0);
    #1;
    chk("cyc_we",      bus0.result_we, 1'b1);
    chk("cyc_val",     bus0.result,    32'd4);
    chk("cyc_w4_val",  bus1.result,    4'd4);
    repeat (11) @(negedge clk);
    #1;
    chk("cyc_val15",   bus0.result,    32'd15);
    chk("cyc_w4_max",  bus1.result,    4'hF);
    chk("cyc_w4_we",   bus1.result_we, 1'b1);
    @(negedge clk);
    #1;
    chk("cyc_w4_wrap", bus1.result,    4'h0);
    bus1.sys_valid = 1'b0;

    // Print with out_ready low
    @(negedge clk);
    issue(1, 32'hDEAD0001);
    #1;
    chk("pr_stall",     bus0.stall,     1'b0);
    chk("pr_we",        bus0.result_we, 1'b0);
    chk("pr_result",    bus0.result,    32'h0);
    chk("pr_latency",   bus0.out_valid, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk("pr_valid",     bus0.out_valid, 1'b1);
    chk("pr_data",      bus0.out_data,  32'hDEAD0001);
    chk("pr_chan",      bus0.out_chan,  2'd0);
    chk("pr_display",   bus0.display,   32'hDEAD0001);

    // Channel select 6 % 4 = 2, then print 7
    @(negedge clk);
    issue(2, 6);
    #1;
    chk("ch_stall",     bus0.stall,     1'b0);
    @(negedge clk);
    issue(1, 7);
    @(negedge clk);
    idle();
    bus0.out_ready = 1'b1;
    #1;
    chk("ch_head0",     bus0.out_data,  32'hDEAD0001);
    @(negedge clk);
    #1;
    chk("ch_data",      bus0.out_data,  32'd7);
    chk("ch_chan",      bus0.out_chan,  2'd2);
    chk("ch_display",   bus0.display,   32'd7);
    @(negedge clk);
    bus0.out_ready = 1'b0;
    #1;
    chk("ch_empty",     bus0.out_valid, 1'b0);

    // Unknown code: no stall, no result, no push
    @(negedge clk);
    issue(7, 5);
    #1;
    chk("unk_stall",    bus0.stall,     1'b0);
    chk("unk_we",       bus0.result_we, 1'b0);
    chk("unk_result",   bus0.result,    32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("unk_nopush",   bus0.out_valid, 1'b0);
    chk("unk_display",  bus0.display,   32'd7);

    // Fill the FIFO, then a 9th print stalls
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(1, 32'(100 + i));
      #1;
      chk("full_nostall", bus0.stall, 1'b0);
    end
    @(negedge clk);
    issue(1, 200);
    #1;
    chk("full_stall1",  bus0.stall, 1'b1);
    @(negedge clk);
    #1;
    chk("full_stall2",  bus0.stall, 1'b1);
    @(negedge clk);
    #1;
    chk("full_stall3",  bus0.stall, 1'b1);
    @(negedge clk);
    bus0.out_ready = 1'b1;
    #1;
    chk("full_pop_stall", bus0.stall, 1'b1);
    @(negedge clk);
    bus0.out_ready = 1'b0;
    #1;
    chk("full_release", bus0.stall,    1'b0);
    chk("full_disp_old", bus0.display, 32'd107);
    chk("full_head",    bus0.out_data, 32'd101);
    @(negedge clk);
    idle();
    bus0.out_ready = 1'b1;
    #1;
    chk("full_disp_new", bus0.display, 32'd200);
    for (int k = 0; k < 7; k++) drain_exp[k] = 32'(101 + k);
    drain_exp[7] = 32'd200;
    for (int k = 0; k < 8; k++) begin
      chk("drain_data", bus0.out_data, drain_exp[k]);
      chk("drain_chan", bus0.out_chan, 2'd2);
      @(negedge clk);
      #1;
    end
    chk("drain_empty", bus0.out_valid, 1'b0);
    bus0.out_ready = 1'b0;

    // Asynchronous reset mid-cycle with 3 entries queued
    @(negedge clk);
    issue(1, 1);
    @(negedge clk);
    issue(1, 2);
    @(negedge clk);
    issue(1, 3);
    @(negedge clk);
    idle();
    #1;
    chk("rq_valid",   bus0.out_valid, 1'b1);
    chk("rq_head",    bus0.out_data,  32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",   bus0.out_valid, 1'b0);
    chk("ar_halted",  bus0.halted,    1'b0);
    chk("ar_display", bus0.display,   32'h0);
    bus0.out_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(30, 0);
    #1;
    chk("ar_nopop",   bus0.out_valid, 1'b0);
    chk("ar_cyc",     bus0.result,    32'd4);
    @(negedge clk);
    idle();
    bus0.out_ready = 1'b0;

    // Halt with two prints queued
    @(negedge clk);
    issue(1, 32'hA1);
    @(negedge clk);
    issue(1, 32'hA2);
    @(negedge clk);
    issue(10, 0);
    #1;
    chk("h_not_yet",  bus0.halted,    1'b0);
    chk("h_stall",    bus0.stall,     1'b0);
    @(negedge clk);
    issue(1, 32'hA3);
    #1;
    chk("h_halted",   bus0.halted,    1'b1);
    chk("h_pr_stall", bus0.stall,     1'b0);
    @(negedge clk);
    issue(30, 0);
    #1;
    chk("h_cyc_we",   bus0.result_we, 1'b0);
    chk("h_cyc_val",  bus0.result,    32'h0);
    @(negedge clk);
    idle();
    bus0.out_ready = 1'b1;
    #1;
    chk("h_head1",    bus0.out_data,  32'hA1);
    chk("h_chan1",    bus0.out_chan,  2'd0);
    chk("h_display",  bus0.display,   32'hA2);
    @(negedge clk);
    #1;
    chk("h_head2",    bus0.out_data,  32'hA2);
    @(negedge clk);
    #1;
    chk("h_empty",    bus0.out_valid, 1'b0);
    chk("h_sticky",   bus0.halted,    1'b1);
    bus0.out_ready = 1'b0;

    // Reset clears halt
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("fr_halted",  bus0.halted,    1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
